// File: rtl/nf10_axis_pkt_gen_if.sv
// nf10_axis_pkt_gen_if
//   AXI4-Stream bundle between the packet generator, which is the master, and
//   the s_axis port of the 10G interface, which is the slave.
//   master: drives tdata, tstrb, tuser, tvalid and tlast; samples tready.
//   slave : samples the payload and valid signals; drives tready.
interface nf10_axis_pkt_gen_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_pkt_gen.sv
// nf10_axis_pkt_gen
//   Programmable AXI4-Stream packet generator. It sends num_pkts packets of
//   clamp(pkt_len) bytes with ipg idle cycles between packets. The payload
//   pattern is {16'hCAFE, seq, beat, len}.
//   axi_aclk, axi_reset : clock and synchronous active-high reset
//   start               : one-cycle request, ignored while busy
//   num_pkts, pkt_len,
//   ipg, src_port,
//   dst_port            : configuration, latched when start is accepted
//   m_axis              : AXI4-Stream master; every output is registered
//   busy, done          : run in progress / one-cycle completion pulse
//   pkts_sent           : number of packets whose tlast beat was handshaked
//
//   state | meaning
//   IDLE  | waiting for start
//   SEND  | presenting beats, advancing on each tvalid && tready
//   GAP   | tvalid low for ipg cycles between packets
module nf10_axis_pkt_gen #(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_LEN_MIN            = 60,
    parameter int C_LEN_MAX            = 9600
) (
    input  logic                      axi_aclk,
    input  logic                      axi_reset,
    input  logic                      start,
    input  logic [15:0]               num_pkts,
    input  logic [15:0]               pkt_len,
    input  logic [7:0]                ipg,
    input  logic [7:0]                src_port,
    input  logic [7:0]                dst_port,
    nf10_axis_pkt_gen_if.master       m_axis,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               pkts_sent
);
    localparam logic [15:0] LEN_MIN = 16'(C_LEN_MIN);
    localparam logic [15:0] LEN_MAX = 16'(C_LEN_MAX);
    localparam int          STRB_W  = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t state_q, state_d;
    logic [15:0] len_q, len_d, beats_q, beats_d, num_q, num_d;
    logic [15:0] seq_q, seq_d, beat_q, beat_d, sent_q, sent_d;
    logic [7:0]  ipg_q, ipg_d, gap_q, gap_d, src_q, src_d, dst_q, dst_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [STRB_W-1:0]               tstrb_q, tstrb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d, done_q, done_d;

    // Describes the beat to present next cycle whenever emit is set.
    logic        emit;
    logic [15:0] e_len, e_beats, e_seq, e_beat;
    logic [7:0]  e_src, e_dst;
    logic [15:0] clamp_len, clamp_beats;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        beats_d  = beats_q;
        num_d    = num_q;
        ipg_d    = ipg_q;
        src_d    = src_q;
        dst_d    = dst_q;
        seq_d    = seq_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        sent_d   = sent_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        emit     = 1'b0;
        e_len    = len_q;
        e_beats  = beats_q;
        e_src    = src_q;
        e_dst    = dst_q;
        e_seq    = seq_q;
        e_beat   = beat_q;

        clamp_len   = (pkt_len < LEN_MIN) ? LEN_MIN :
                      (pkt_len > LEN_MAX) ? LEN_MAX : pkt_len;
        clamp_beats = (clamp_len + 16'd7) >> 3;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = clamp_len;
                    beats_d = clamp_beats;
                    num_d   = num_pkts;
                    ipg_d   = ipg;
                    src_d   = src_port;
                    dst_d   = dst_port;
                    seq_d   = 16'd0;
                    beat_d  = 16'd0;
                    sent_d  = 16'd0;
                    if (num_pkts == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = SEND;
                        emit    = 1'b1;
                        e_len   = clamp_len;
                        e_beats = clamp_beats;
                        e_src   = src_port;
                        e_dst   = dst_port;
                        e_seq   = 16'd0;
                        e_beat  = 16'd0;
                    end
                end
            end
            SEND: begin
                if (tvalid_q && m_axis.tready) begin
                    if (tlast_q) begin
                        sent_d = sent_q + 16'd1;
                        if (seq_q + 16'd1 == num_q) begin
                            state_d  = IDLE;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            tdata_d  = '0;
                            tstrb_d  = '0;
                            tuser_d  = '0;
                        end else begin
                            seq_d  = seq_q + 16'd1;
                            beat_d = 16'd0;
                            if (ipg_q == 8'd0) begin
                                emit   = 1'b1;
                                e_seq  = seq_q + 16'd1;
                                e_beat = 16'd0;
                            end else begin
                                state_d  = GAP;
                                gap_d    = ipg_q;
                                tvalid_d = 1'b0;
                                tlast_d  = 1'b0;
                            end
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                        emit   = 1'b1;
                        e_beat = beat_q + 16'd1;
                    end
                end
            end
            GAP: begin
                // gap_q counts ipg..1, giving exactly ipg cycles with tvalid low.
                gap_d = gap_q - 8'd1;
                if (gap_q == 8'd1) begin
                    state_d = SEND;
                    emit    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            tvalid_d = 1'b1;
            tdata_d  = {16'hCAFE, e_seq, e_beat, e_len};
            tlast_d  = (e_beat == e_beats - 16'd1);
            // The shift by (0 - L mod 8) mod 8 keeps the low L mod 8 bytes, and all 8 when the remainder is 0.
            tstrb_d  = tlast_d ? (8'hFF >> (3'd0 - e_len[2:0])) : 8'hFF;
            tuser_d  = {96'h0, e_dst, e_src, e_len};
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            beats_q  <= '0;
            num_q    <= '0;
            ipg_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            seq_q    <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            sent_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            beats_q  <= beats_d;
            num_q    <= num_d;
            ipg_q    <= ipg_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            seq_q    <= seq_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            sent_q   <= sent_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tstrb  = tstrb_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkts_sent     = sent_q;
endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// tb_nf10_axis_pkt_gen
//   Table-driven bench for nf10_axis_pkt_gen. Each table row holds a
//   configuration and its hand-computed length, beat count and last-beat
//   strobe. A small model then predicts every beat. The reset-idle,
//   zero-packet and mid-packet reset cases are written out as sequences.
module tb_nf10_axis_pkt_gen;
    logic        clk = 1'b0;
    logic        axi_reset;
    logic        start;
    logic [15:0] num_pkts, pkt_len;
    logic [7:0]  ipg, src_port, dst_port;
    logic        busy, done;
    logic [15:0] pkts_sent;

    int checks = 0;
    int errors = 0;

    nf10_axis_pkt_gen_if axis ();

    nf10_axis_pkt_gen dut (
        .axi_aclk  (clk),
        .axi_reset (axi_reset),
        .start     (start),
        .num_pkts  (num_pkts),
        .pkt_len   (pkt_len),
        .ipg       (ipg),
        .src_port  (src_port),
        .dst_port  (dst_port),
        .m_axis    (axis),
        .busy      (busy),
        .done      (done),
        .pkts_sent (pkts_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] num;
        logic [15:0] len;
        logic [7:0]  ipg;
        logic [7:0]  src;
        logic [7:0]  dst;
        bit          rnd;
        bit          poke;
        logic [15:0] exp_l;
        logic [15:0] exp_b;
        logic [7:0]  exp_strb;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  n, k, gap, cyc;
        bit  in_gap, fin, ready, seen;
        logic [63:0]  exp_data;
        logic [127:0] exp_user;
        num_pkts = v.num;
        pkt_len  = v.len;
        ipg      = v.ipg;
        src_port = v.src;
        dst_port = v.dst;
        axis.tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (v.num == 16'd0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_sent", pkts_sent, 0);
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (axis.tvalid) seen = 1'b1;
                tick();
            end
            chk("zero_no_valid", seen, 0);
            return;
        end
        chk("start_busy", busy, 1);
        chk("start_valid", axis.tvalid, 1);
        chk("start_sent", pkts_sent, 0);
        n = 0; k = 0; gap = 0; cyc = 0; in_gap = 1'b0; fin = 1'b0;
        while (!fin && cyc < 20000) begin
            ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axis.tready = ready;
            if (v.poke && cyc == 5) begin
                start = 1'b1; num_pkts = 16'd7; pkt_len = 16'd200;
                ipg = 8'd0; src_port = 8'hEE; dst_port = 8'hDD;
            end else begin
                start = 1'b0;
            end
            chk("busy_run", busy, 1);
            if (axis.tvalid) begin
                if (in_gap) begin
                    chk("gap_len", gap, v.ipg);
                    in_gap = 1'b0;
                end
                exp_data = {16'hCAFE, 16'(n), 16'(k), v.exp_l};
                exp_user = {96'h0, v.dst, v.src, v.exp_l};
                chk("tdata", axis.tdata, exp_data);
                chk("tuser", axis.tuser, exp_user);
                chk("tlast", axis.tlast, (k == int'(v.exp_b) - 1));
                chk("tstrb", axis.tstrb, (k == int'(v.exp_b) - 1) ? v.exp_strb : 8'hFF);
                if (ready) begin
                    if (k == int'(v.exp_b) - 1) begin
                        n++;
                        k = 0;
                        gap = 0;
                        if (n == int'(v.num)) fin = 1'b1;
                        else in_gap = 1'b1;
                    end else begin
                        k++;
                    end
                end
            end else if (in_gap) begin
                gap++;
            end else begin
                chk("valid_drop", axis.tvalid, 1);
            end
            tick();
            cyc++;
            chk("pkts_sent", pkts_sent, 16'(n));
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d packets, expected %0d", n, v.num);
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", axis.tvalid, 0);
        chk("end_sent", pkts_sent, v.num);
        tick();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        vec_t rst_vec;
        int   cyc;
        bit   seen;
        vecs[0] = '{16'd1, 16'd64,    8'd0, 8'h11, 8'h22, 1'b0, 1'b0, 16'd64,   16'd8,    8'hFF};
        vecs[1] = '{16'd1, 16'd65,    8'd0, 8'h33, 8'h44, 1'b0, 1'b0, 16'd65,   16'd9,    8'h01};
        vecs[2] = '{16'd1, 16'd10,    8'd0, 8'h55, 8'h66, 1'b0, 1'b0, 16'd60,   16'd8,    8'h0F};
        vecs[3] = '{16'd1, 16'd128,   8'd0, 8'h01, 8'h02, 1'b1, 1'b0, 16'd128,  16'd16,   8'hFF};
        vecs[4] = '{16'd3, 16'd64,    8'd4, 8'hA1, 8'hB2, 1'b0, 1'b0, 16'd64,   16'd8,    8'hFF};
        vecs[5] = '{16'd3, 16'd64,    8'd0, 8'hA1, 8'hB2, 1'b0, 1'b0, 16'd64,   16'd8,    8'hFF};
        vecs[6] = '{16'd0, 16'd64,    8'd0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd64,   16'd8,    8'hFF};
        vecs[7] = '{16'd2, 16'd100,   8'd3, 8'h12, 8'h34, 1'b1, 1'b1, 16'd100,  16'd13,   8'h0F};
        vecs[8] = '{16'd1, 16'd61,    8'd0, 8'h77, 8'h88, 1'b1, 1'b0, 16'd61,   16'd8,    8'h1F};
        vecs[9] = '{16'd2, 16'd10000, 8'd1, 8'h5A, 8'hA5, 1'b1, 1'b0, 16'd9600, 16'd1200, 8'hFF};

        axi_reset = 1'b1;
        start = 1'b0;
        num_pkts = '0; pkt_len = '0; ipg = '0; src_port = '0; dst_port = '0;
        axis.tready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", axis.tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", pkts_sent, 0);
        axi_reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
            repeat (2) tick();
        end

        // Reset during beat 3 of packet 1.
        axis.tready = 1'b1;
        num_pkts = 16'd3; pkt_len = 16'd64; ipg = 8'd2;
        src_port = 8'h0A; dst_port = 8'h0B;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(axis.tvalid && axis.tdata[47:32] == 16'd1 && axis.tdata[31:16] == 16'd3) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("reach_p1_b3", cyc < 200, 1);
        axi_reset = 1'b1;
        tick();
        axi_reset = 1'b0;
        chk("mid_rst_valid", axis.tvalid, 0);
        chk("mid_rst_last", axis.tlast, 0);
        chk("mid_rst_data", axis.tdata, 0);
        chk("mid_rst_strb", axis.tstrb, 0);
        chk("mid_rst_user", axis.tuser, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sent", pkts_sent, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (axis.tvalid || axis.tlast || done) seen = 1'b1;
        end
        chk("post_rst_quiet", seen, 0);
        rst_vec = '{16'd2, 16'd64, 8'd1, 8'h0C, 8'h0D, 1'b0, 1'b0, 16'd64, 16'd8, 8'hFF};
        run_vec(rst_vec);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nf10_axis_pkt_gen.md
Name: nf10_axis_pkt_gen

Overview:
- Programmable AXI4-Stream packet generator for the loopback test design.
- Drives the s_axis slave port of a 10G interface, i.e. it is the transmitter end of that interface's 64-bit data / 128-bit tuser stream.
- Emits N packets of a configured byte length, a fixed inter-packet gap, and a checkable payload pattern.
- Reports progress via busy, done and sent-count.

Parameters:
- C_M_AXIS_DATA_WIDTH, 64, tdata width; only 64 is supported, so tstrb is 8 bits.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width.
- C_LEN_MIN, 60, minimum packet length in bytes; shorter requests are clamped up.
- C_LEN_MAX, 9600, maximum packet length in bytes; longer requests are clamped down.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_reset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only while busy=0.
- num_pkts  in  16  number of packets to send; latched on start.
- pkt_len  in  16  packet length in bytes; latched on start, then clamped.
- ipg  in  8  idle cycles between packets; latched on start.
- src_port  in  8  value placed in tuser[23:16]; latched on start.
- dst_port  in  8  value placed in tuser[31:24]; latched on start.
- m_axis_tdata  out  64  payload word.
- m_axis_tstrb  out  8  byte enables.
- m_axis_tuser  out  128  packet metadata.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high from start acceptance until completion.
- done  out  1  one-cycle completion pulse.
- pkts_sent  out  16  count of packets fully handshaked.

Behaviour:
- Reset: synchronous on axi_reset=1. All outputs go to 0 at the next edge (tvalid, tlast, tdata, tstrb, tuser, busy, done, pkts_sent). The FSM enters IDLE.
- Reset mid-packet: the packet is abandoned without tlast and no done pulse is generated.
- States: IDLE, SEND, GAP.
- IDLE:
  - start=1 at cycle t latches config, clears pkts_sent and sets busy=1 at t+1.
  - Zero-packet case: if num_pkts=0, done=1 at t+1, busy stays 0 and the FSM stays in IDLE.
  - Normal case: otherwise go to SEND with tvalid=1 at t+1.
- start while busy=1 is ignored.
- Length: L = clamp(pkt_len, C_LEN_MIN, C_LEN_MAX). Beats B = ceil(L/8).
- Beat fields, beat index k = 0..B-1, packet sequence n = 0..num_pkts-1:
  - tdata = {16'hCAFE, n[15:0], k[15:0], L[15:0]}.
  - tstrb = 8'hFF on all beats except the last. On the last beat, the low (L mod 8) bits are set, or 8'hFF if L mod 8 = 0.
  - tlast = 1 only on beat B-1.
  - tuser = {96'h0, dst_port, src_port, L[15:0]}, held on every beat of the packet.
- AXIS rules:
  - A beat transfers on tvalid&&tready.
  - While tvalid=1 and tready=0, tdata, tstrb, tuser and tlast are held stable and tvalid is not dropped.
  - All outputs are registered. tready has no combinational path to any output.
- After the tlast handshake:
  - pkts_sent increments in the same edge.
  - More packets and ipg=0: next packet beat 0 is valid in the very next cycle (back-to-back, tvalid stays 1).
  - More packets and ipg>0: go to GAP with tvalid=0 for exactly ipg cycles, then SEND with tvalid=1.
  - Last packet: the FSM returns to IDLE, busy=0 and done=1 for one cycle in the cycle after the final handshake.
- Counters: beat counter 16-bit and sequence counter 16-bit. No wrap occurs within the legal ranges.

Test Plan:
1. pkt_len=64, num_pkts=1, ipg=0, tready=1, start at t -> tvalid t+1..t+8, tlast at t+8, tstrb all 8'hFF, tuser[31:0]={dst,src,16'd64}, done at t+9, pkts_sent=1.
2. pkt_len=65 -> 9 beats, last tstrb=8'h01. pkt_len=10 -> clamped to L=60: 8 beats, last tstrb=8'h0F, tuser[15:0]=60, tdata[15:0]=60.
3. pkt_len=128, tready toggling randomly (~50%) -> each beat held stable while stalled, k increments 0..15 with no gaps or repeats, exactly one tlast.
4. num_pkts=3, ipg=4, pkt_len=64 -> exactly 4 tvalid=0 cycles between each tlast handshake and the next beat 0; n field = 0,1,2; pkts_sent ends at 3. Repeat with ipg=0 -> 24 consecutive valid beats.
5. num_pkts=0 -> done at t+1, tvalid never asserts. A second start pulsed mid-run -> ignored, with no change to the packet count or pattern.
6. axi_reset=1 during beat 3 of packet 1 -> all outputs 0 next cycle, no tlast, no done. A subsequent start runs a full fresh sequence from n=0.
